// File: rtl/zx48_pkg.sv
// Shared constants for the zx48 memory subsystem: grant owner codes and
// the SRAM scheduler state encoding.
package zx48_pkg;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_LDR  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

endpackage

// File: rtl/sram_scheduler.sv
// Time-slot arbiter sharing the single external 8-bit SRAM between video,
// CPU and ROM loader; sequences address, data, output enable and write strobe.
module sram_scheduler
  import zx48_pkg::*;
#(
  parameter int AW   = 21,
  parameter int SLOT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vidReq,
  input  logic [AW-1:0] vidA,
  output logic [7:0]    vidQ,
  output logic          vidAck,
  input  logic          cpuReq,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuAck,
  input  logic          ldrReq,
  input  logic [AW-1:0] ldrA,
  input  logic [7:0]    ldrD,
  output logic          ldrAck,
  output logic [AW-1:0] sramA,
  output logic [7:0]    sramDo,
  output logic          sramDoe,
  input  logic [7:0]    sramDi,
  output logic          sramWe,
  output logic [1:0]    gnt
);

  localparam int CW = $clog2(SLOT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
  // Last cnt value whose successor still lies inside the write strobe.
  localparam logic [CW-1:0] CNT_STROBE_END = CW'(SLOT - 3);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    owner;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          wr;
  logic          we;
  logic          doe;
  logic [7:0]    vid_q;
  logic [7:0]    cpu_q;
  logic          vid_ack;
  logic          cpu_ack;
  logic          ldr_ack;

  // A requester still showing its ack is holding a stale request.
  logic vid_ok;
  logic cpu_ok;
  logic ldr_ok;
  assign vid_ok = vidReq & ~vid_ack;
  assign cpu_ok = cpuReq & ~cpu_ack;
  assign ldr_ok = ldrReq & ~ldr_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      owner   <= GNT_NONE;
      addr    <= '0;
      wdata   <= '0;
      wr      <= 1'b0;
      we      <= 1'b1;
      doe     <= 1'b0;
      vid_q   <= '0;
      cpu_q   <= '0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      if (state == ST_IDLE) begin
        if (vid_ok) begin
          owner <= GNT_VID;
          addr  <= vidA;
          wr    <= 1'b0;
          doe   <= 1'b0;
          state <= ST_ACC;
          cnt   <= '0;
        end else if (cpu_ok) begin
          owner <= GNT_CPU;
          addr  <= cpuA;
          wdata <= cpuD;
          wr    <= cpuWr;
          doe   <= cpuWr;
          state <= ST_ACC;
          cnt   <= '0;
        end else if (ldr_ok) begin
          owner <= GNT_LDR;
          addr  <= ldrA;
          wdata <= ldrD;
          wr    <= 1'b1;
          doe   <= 1'b1;
          state <= ST_ACC;
          cnt   <= '0;
        end
      end else begin
        if (cnt == CNT_LAST) begin
          state   <= ST_IDLE;
          owner   <= GNT_NONE;
          cnt     <= '0;
          doe     <= 1'b0;
          we      <= 1'b1;
          vid_ack <= (owner == GNT_VID);
          cpu_ack <= (owner == GNT_CPU);
          ldr_ack <= (owner == GNT_LDR);
          if (!wr && owner == GNT_VID) vid_q <= sramDi;
          if (!wr && owner == GNT_CPU) cpu_q <= sramDi;
        end else begin
          cnt <= cnt + CW'(1);
          we  <= ~(wr && cnt <= CNT_STROBE_END);
        end
      end
    end
  end

  assign sramA   = addr;
  assign sramDo  = wdata;
  assign sramDoe = doe;
  assign sramWe  = we;
  assign gnt     = owner;
  assign vidQ    = vid_q;
  assign cpuQ    = cpu_q;
  assign vidAck  = vid_ack;
  assign cpuAck  = cpu_ack;
  assign ldrAck  = ldr_ack;

endmodule

// File: tb/tb_sram_scheduler.sv
// Scoreboard bench for sram_scheduler: drivers push expected accesses,
// a negedge monitor checks each access and its ack against a memory model.
module tb_sram_scheduler;
  import zx48_pkg::*;

  localparam int AW   = 21;
  localparam int SLOT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vidReq = 1'b0;
  logic [AW-1:0] vidA = '0;
  logic [7:0]    vidQ;
  logic          vidAck;
  logic          cpuReq = 1'b0;
  logic          cpuWr = 1'b0;
  logic [AW-1:0] cpuA = '0;
  logic [7:0]    cpuD = '0;
  logic [7:0]    cpuQ;
  logic          cpuAck;
  logic          ldrReq = 1'b0;
  logic [AW-1:0] ldrA = '0;
  logic [7:0]    ldrD = '0;
  logic          ldrAck;
  logic [AW-1:0] sramA;
  logic [7:0]    sramDo;
  logic          sramDoe;
  logic [7:0]    sramDi = '0;
  logic          sramWe;
  logic [1:0]    gnt;

  always #5 clock = ~clock;

  sram_scheduler #(.AW(AW), .SLOT(SLOT)) dut (
    .clock(clock), .reset(reset),
    .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
    .ldrReq(ldrReq), .ldrA(ldrA), .ldrD(ldrD), .ldrAck(ldrAck),
    .sramA(sramA), .sramDo(sramDo), .sramDoe(sramDoe), .sramDi(sramDi),
    .sramWe(sramWe), .gnt(gnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          wr;
  } acc_t;

  acc_t q_vid[$];
  acc_t q_cpu[$];
  acc_t q_ldr[$];
  logic [7:0] sram_mem[int];
  logic [7:0] ref_mem[int];
  int glog_id[$];
  int glog_cyc[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_vid_q = '0;
  logic [7:0] exp_cpu_q = '0;

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [AW-1:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  // Write strobe expected over cnt 0..SLOT-1: low only strictly inside the slot.
  function automatic logic [SLOT-1:0] exp_we(input logic w);
    logic [SLOT-1:0] p;
    for (int i = 0; i < SLOT; i++) p[i] = !(w && i >= 1 && i <= SLOT - 2);
    return p;
  endfunction

  function automatic logic [2:0] ack_bits(input logic [1:0] id);
    return {id == GNT_VID, id == GNT_CPU, id == GNT_LDR};
  endfunction

  function automatic int q_size(input logic [1:0] id);
    case (id)
      GNT_VID: return q_vid.size();
      GNT_CPU: return q_cpu.size();
      GNT_LDR: return q_ldr.size();
      default: return 0;
    endcase
  endfunction

  function automatic acc_t q_front(input logic [1:0] id);
    case (id)
      GNT_VID: return q_vid[0];
      GNT_CPU: return q_cpu[0];
      default: return q_ldr[0];
    endcase
  endfunction

  task automatic q_pop(input logic [1:0] id);
    case (id)
      GNT_VID: void'(q_vid.pop_front());
      GNT_CPU: void'(q_cpu.pop_front());
      GNT_LDR: void'(q_ldr.pop_front());
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: written on each clock the strobe is low, read data presented at negedge.
  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
    if (!reset && !sramWe) sram_mem[int'(sramA)] = sramDo;
  end

  initial forever begin
    @(negedge clock);
    sramDi = sram_rd(sramA);
  end

  // Monitor: follows each granted access and scores it when its ack appears.
  logic [1:0]      act_id = GNT_NONE;
  logic            active = 1'b0;
  acc_t            cur;
  int              k = 0;
  logic [SLOT-1:0] we_pat = '1;
  logic            bus_bad = 1'b0;
  logic [7:0]      rd;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      active = 1'b0;
    end else begin
      if (vidAck || cpuAck || ldrAck) begin
        if (!active) begin
          check("spurious_ack", {29'd0, vidAck, cpuAck, ldrAck}, 32'd0);
        end else begin
          check("ack_owner", {29'd0, vidAck, cpuAck, ldrAck}, {29'd0, ack_bits(act_id)});
          check("access_len", k, SLOT);
          check("we_shape", {{(32-SLOT){1'b0}}, we_pat}, {{(32-SLOT){1'b0}}, exp_we(cur.wr)});
          check("bus_stable", {31'd0, bus_bad}, 32'd0);
          q_pop(act_id);
          if (cur.wr) begin
            ref_mem[int'(cur.addr)] = cur.data;
            if (act_id == GNT_CPU) check("cpuq_hold_on_write", {24'd0, cpuQ}, {24'd0, exp_cpu_q});
          end else begin
            rd = ref_rd(cur.addr);
            if (act_id == GNT_VID) begin
              check("vidq_read", {24'd0, vidQ}, {24'd0, rd});
              exp_vid_q = rd;
            end else begin
              check("cpuq_read", {24'd0, cpuQ}, {24'd0, rd});
              exp_cpu_q = rd;
            end
          end
          active = 1'b0;
        end
      end
      if (gnt != GNT_NONE) begin
        if (!active) begin
          glog_id.push_back(int'(gnt));
          glog_cyc.push_back(cyc);
          if (q_size(gnt) == 0) begin
            check("unexpected_grant", {30'd0, gnt}, {30'd0, GNT_NONE});
          end else begin
            active  = 1'b1;
            act_id  = gnt;
            cur     = q_front(gnt);
            k       = 0;
            we_pat  = '1;
            bus_bad = 1'b0;
            check("grant_addr", {{(32-AW){1'b0}}, sramA}, {{(32-AW){1'b0}}, cur.addr});
          end
        end
        if (active) begin
          if (gnt != act_id) bus_bad = 1'b1;
          if (k < SLOT) we_pat[k] = sramWe;
          if (sramDoe !== cur.wr) bus_bad = 1'b1;
          if (cur.wr && sramDo !== cur.data) bus_bad = 1'b1;
          if (sramA !== cur.addr) bus_bad = 1'b1;
          k++;
        end
      end
    end
  end

  // Raise a request at a negedge, wait for its ack; lat counts edges from first sampling edge.
  task automatic issue(input logic [1:0] id, input logic w, input logic [AW-1:0] a,
                       input logic [7:0] d, input bit keep, output int lat);
    acc_t e;
    int   c0;
    bit   seen;
    e.addr = a;
    e.data = d;
    e.wr   = (id == GNT_LDR) ? 1'b1 : w;
    case (id)
      GNT_VID: begin vidReq = 1'b1; vidA = a; end
      GNT_CPU: begin cpuReq = 1'b1; cpuWr = w; cpuA = a; cpuD = d; end
      default: begin ldrReq = 1'b1; ldrA = a; ldrD = d; end
    endcase
    case (id)
      GNT_VID: q_vid.push_back(e);
      GNT_CPU: q_cpu.push_back(e);
      default: q_ldr.push_back(e);
    endcase
    c0   = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clock);
      if ((id == GNT_VID && vidAck) || (id == GNT_CPU && cpuAck) || (id == GNT_LDR && ldrAck)) begin
        seen = 1'b1;
        lat  = cyc - c0 - 1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: requester %0d got no ack, expected one within 2000 cycles", id);
    end
    if (!keep || !seen) begin
      case (id)
        GNT_VID: vidReq = 1'b0;
        GNT_CPU: cpuReq = 1'b0;
        default: ldrReq = 1'b0;
      endcase
    end
  endtask

  task automatic rand_stream(input logic [1:0] id, input int n);
    int lat;
    bit keep;
    keep = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
      keep = bit'($urandom_range(0, 1));
      issue(id, (id == GNT_CPU) ? 1'($urandom_range(0, 1)) : 1'b0,
            AW'($urandom_range(0, 7)), 8'($urandom), keep, lat);
    end
    case (id)
      GNT_VID: vidReq = 1'b0;
      GNT_CPU: cpuReq = 1'b0;
      default: ldrReq = 1'b0;
    endcase
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    acc_t e;
    int   c0;
    int   lat;
    int   l1, l2, l3;
    bit   seen;

    // Reset with a CPU write already pending.
    cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 21'h00100; cpuD = 8'h77;
    e.addr = cpuA; e.data = cpuD; e.wr = 1'b1;
    q_cpu.push_back(e);
    repeat (3) begin
      @(negedge clock);
      check("we_in_reset", {31'd0, sramWe}, 32'd1);
    end
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_doe", {31'd0, sramDoe}, 32'd0);
    check("rst_addr", {{(32-AW){1'b0}}, sramA}, 32'd0);
    check("rst_do", {24'd0, sramDo}, 32'd0);
    check("rst_acks", {29'd0, vidAck, cpuAck, ldrAck}, 32'd0);
    check("rst_vidq", {24'd0, vidQ}, 32'd0);
    check("rst_cpuq", {24'd0, cpuQ}, 32'd0);
    reset = 1'b0;
    c0 = cyc;
    @(negedge clock);
    check("gnt_after_reset", {30'd0, gnt}, {30'd0, GNT_CPU});
    seen = 1'b0;
    lat = -1;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (cpuAck) begin seen = 1'b1; lat = cyc - c0 - 1; end
      else @(negedge clock);
    end
    check("reset_latency", lat, SLOT);
    cpuReq = 1'b0;
    @(negedge clock);

    // Video read.
    sram_mem[int'(21'h04000)] = 8'h5A;
    ref_mem[int'(21'h04000)]  = 8'h5A;
    issue(GNT_VID, 1'b0, 21'h04000, 8'h00, 1'b0, lat);
    check("vid_latency", lat, SLOT);
    check("vid_read_data", {24'd0, vidQ}, 32'h5A);

    // CPU write then read-back.
    issue(GNT_CPU, 1'b1, 21'h08000, 8'hC3, 1'b0, lat);
    check("cpu_wr_latency", lat, SLOT);
    check("write_landed", {24'd0, sram_rd(21'h08000)}, 32'hC3);
    check("cpuq_after_write", {24'd0, cpuQ}, 32'd0);
    issue(GNT_CPU, 1'b0, 21'h08000, 8'h00, 1'b0, lat);
    check("cpu_readback", {24'd0, cpuQ}, 32'hC3);

    // Three simultaneous requesters.
    @(negedge clock);
    glog_id.delete();
    glog_cyc.delete();
    fork
      issue(GNT_VID, 1'b0, 21'h00010, 8'h00, 1'b0, l1);
      issue(GNT_CPU, 1'b1, 21'h00011, 8'hA1, 1'b0, l2);
      issue(GNT_LDR, 1'b1, 21'h00012, 8'hB2, 1'b0, l3);
    join
    check("simul_grants", glog_id.size(), 3);
    if (glog_id.size() == 3) begin
      check("simul_order0", glog_id[0], GNT_VID);
      check("simul_order1", glog_id[1], GNT_CPU);
      check("simul_order2", glog_id[2], GNT_LDR);
      check("simul_gap0", glog_cyc[1] - glog_cyc[0], SLOT + 1);
      check("simul_gap1", glog_cyc[2] - glog_cyc[1], SLOT + 1);
    end
    check("simul_lat_vid", l1, SLOT);
    check("simul_lat_cpu", l2, 2 * SLOT + 1);
    check("simul_lat_ldr", l3, 3 * SLOT + 2);

    // Loader back-to-back burst with req held through ack.
    @(negedge clock);
    glog_id.delete();
    glog_cyc.delete();
    for (int i = 0; i < 4; i++)
      issue(GNT_LDR, 1'b1, AW'(i), 8'(8'h10 + i), (i < 3), lat);
    check("ldr_grants", glog_id.size(), 4);
    for (int i = 1; i < 4 && i < glog_cyc.size(); i++)
      check("ldr_gap", glog_cyc[i] - glog_cyc[i-1], SLOT + 2);
    for (int i = 0; i < 4; i++)
      check("ldr_mem", {24'd0, sram_rd(AW'(i))}, 32'(8'h10 + i));

    // Randomized concurrent traffic.
    @(negedge clock);
    fork
      rand_stream(GNT_VID, 30);
      rand_stream(GNT_CPU, 30);
      rand_stream(GNT_LDR, 30);
    join
    repeat (3) @(negedge clock);

    // Reset in the middle of a write strobe.
    cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 21'h1FFFF0; cpuD = 8'hEE;
    e.addr = cpuA; e.data = cpuD; e.wr = 1'b1;
    q_cpu.push_back(e);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (!sramWe) seen = 1'b1;
    end
    check("abort_we_seen", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_we", {31'd0, sramWe}, 32'd1);
    check("abort_doe", {31'd0, sramDoe}, 32'd0);
    check("abort_gnt", {30'd0, gnt}, 32'd0);
    q_cpu.delete();
    cpuReq = 1'b0;
    exp_cpu_q = '0;
    exp_vid_q = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      check("abort_no_ack", {29'd0, vidAck, cpuAck, ldrAck}, 32'd0);
    end
    check("abort_idle_gnt", {30'd0, gnt}, 32'd0);
    check("abort_cpuq", {24'd0, cpuQ}, 32'd0);

    check("drain_vid", q_vid.size(), 0);
    check("drain_cpu", q_cpu.size(), 0);
    check("drain_ldr", q_ldr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_scheduler.md
# sram_scheduler

Time-slot arbiter for the single external 8-bit SRAM in zx48. It shares the SRAM between three requesters: the video fetch path, the Z80 bus, and the power-up ROM loader. It sequences the address, data, output-enable and write-strobe timing. It sits between the memory front-end and the board SRAM pins; tristating of the DQ bus happens at top level.

## Interface
Parameters:
- AW, 21, SRAM address width.
- SLOT, 4, clocks per SRAM access (minimum 3).

Ports:
- clock  in  1  system clock, 56 MHz.
- reset  in  1  asynchronous, active-high.
- vidReq  in  1  video read request; held until ack.
- vidA  in  AW  video address.
- vidQ  out  8  video read data.
- vidAck  out  1  one-cycle completion pulse.
- cpuReq  in  1  CPU request; held until ack.
- cpuWr  in  1  1 = write, 0 = read.
- cpuA  in  AW  CPU address.
- cpuD  in  8  CPU write data.
- cpuQ  out  8  CPU read data.
- cpuAck  out  1  one-cycle completion pulse.
- ldrReq  in  1  loader write request; held until ack.
- ldrA  in  AW  loader address.
- ldrD  in  8  loader write data.
- ldrAck  out  1  one-cycle completion pulse.
- sramA  out  AW  SRAM address.
- sramDo  out  8  data driven to SRAM.
- sramDoe  out  1  DQ output enable; top level drives DQ when 1.
- sramDi  in  8  data sampled from SRAM DQ.
- sramWe  out  1  write strobe, active-low.
- gnt  out  2  current owner: 0 none, 1 video, 2 cpu, 3 loader.

## Operation
- States: IDLE, ACC. A counter cnt runs 0..SLOT-1 in ACC.
- Arbitration in IDLE uses fixed priority video > cpu > loader.
  - A requester whose ack is high in the current cycle is not eligible. This masks a stale held req.
  - With no eligible requester, the block stays in IDLE.
- On grant:
  - Register the address, write data and direction of the winner; the loader is always a write.
  - Set gnt, go to ACC with cnt=0.
- Read in ACC:
  - sramWe=1, sramDoe=0, sramA holds the captured address.
  - At the edge ending cnt=SLOT-1, latch sramDi into the owner's Q register.
- Write in ACC:
  - sramDoe=1 and sramDo=data throughout.
  - sramWe=1 at cnt=0 (setup), 0 for cnt=1..SLOT-2, 1 at cnt=SLOT-1 (hold).
- End of access, at the edge ending cnt=SLOT-1:
  - Return to IDLE, gnt=0, sramDoe=0.
  - Pulse the owner's ack high for exactly one cycle.
- vidQ and cpuQ hold their value until the next read by the same requester. A write never alters cpuQ.
- Address and data inputs are sampled only at grant. Later changes do not affect the access in progress.
- The block has no request queue. Priority is re-evaluated at every IDLE cycle.

## Timing
- Reset (asynchronous), values on all outputs:
  - State IDLE, cnt=0, gnt=0.
  - sramWe=1, sramDoe=0, sramA=0, sramDo=0.
  - All acks 0; vidQ=0, cpuQ=0.
- Reset mid-access aborts the access immediately: sramWe rises asynchronously and no ack is issued.
- Request sampled high in IDLE at edge E0 gives:
  - ACC cycles E0..E(SLOT-1).
  - ack high from E(SLOT) to E(SLOT+1).
  - Read data valid on Q from E(SLOT).
- Best-case latency is req to ack = SLOT clocks.
- Throughput is one access per SLOT+1 clocks (5 clocks = 11.2 M accesses/s at SLOT=4).
  - This is enough for video (1.75 M/s) plus CPU (≤ 0.875 M/s at 3.5 MHz with 4T cycles).
- Worst-case CPU wait is one video access plus its own: 2·(SLOT+1)-1 clocks.
- Simultaneous requests: the higher-priority requester is served first. The loser is granted in the IDLE cycle right after the winner's access, which is also the winner's ack cycle.
- A requester that keeps req high across its own ack is served again in the IDLE cycle after ack. A back-to-back pair from one requester is therefore SLOT+2 clocks apart.
- sramA and sramDo change only at grant. The write data is stable through the cycles on each side of the We low pulse.

## Structure
- Shared package zx48_pkg holds:
  - GNT_NONE / GNT_VID / GNT_CPU / GNT_LDR 2-bit constants.
  - The IDLE/ACC state encoding.
- Single module. The priority logic is three lines, and a sub-module is not warranted.
- The top level keeps the DQ tristate: sramDQ = sramDoe ? sramDo : 'z, and sramDi = sramDQ.

## Test plan
- Reset with cpuReq high and cpuWr=1, then release: no sramWe low during reset. Afterwards, grant with gnt=2 and one cpuAck pulse exactly SLOT clocks after the first sampled req.
- Video read, vidA=0x04000 with the SRAM model returning 0x5A: sramWe stays 1 and sramDoe stays 0. vidQ=0x5A and vidAck pulses for 1 cycle at E4.
- CPU write, cpuA=0x08000 and cpuD=0xC3: sramWe low exactly on cnt 1..2 and sramDo=0xC3 on cnt 0..3. The model reads back 0xC3, and cpuQ is unchanged.
- vidReq, cpuReq and ldrReq all rise on the same edge: grant order is video, cpu, loader. Accesses start 5 clocks apart, with one ack each.
- Loader holds ldrReq high through ack with ldrA stepping 0..3 and ldrD=0x10..0x13: the memory ends holding 0x10..0x13 and the grants are 6 clocks apart.
- Reset asserted at cnt=1 of a write: sramWe=1 and sramDoe=0 immediately. There is no ack, and after release the block is IDLE with gnt=0.
